// File: rtl/modulo3_serializer.sv
// rtl/modulo3_serializer.sv - parallel word to MSB-first serial stream with running mod-3 remainder
module modulo3_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic [1:0]       rem_out,
    output logic             rem_valid,
    output logic             divisible
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_rem;
    logic [1:0]       r_rem_out;
    logic             r_rem_valid;

    logic             w_accept;
    logic             w_xfer;
    logic             w_cnt_zero;
    logic [1:0]       w_rem_next;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_xfer       = 1'b0;
        w_cnt_zero   = (r_cnt == '0);
        case (r_state)
            S_IDLE: begin
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_xfer = ser_ready;
                if (ser_ready && w_cnt_zero) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // (2r + b) mod 3 as a lookup on the 2-bit remainder so no wider sum is ever formed
    always_comb begin
        w_rem_next = 2'd0;
        case (r_rem)
            2'd0:    w_rem_next = r_shift[WIDTH-1] ? 2'd1 : 2'd0;
            2'd1:    w_rem_next = r_shift[WIDTH-1] ? 2'd0 : 2'd2;
            default: w_rem_next = r_shift[WIDTH-1] ? 2'd2 : 2'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_rem       <= 2'd0;
            r_rem_out   <= 2'd0;
            r_rem_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rem_valid <= 1'b0;
            if (w_accept) begin
                r_shift <= in_data;
                r_cnt   <= LAST_IDX;
                r_rem   <= 2'd0;
            end else if (w_xfer) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                r_cnt   <= r_cnt - CW'(1);
                r_rem   <= w_rem_next;
                if (w_cnt_zero) begin
                    r_rem_out   <= w_rem_next;
                    r_rem_valid <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign ser_valid = (r_state == S_SHIFT);
    assign ser_bit   = ser_valid & r_shift[WIDTH-1];
    assign ser_first = ser_valid && (r_cnt == LAST_IDX);
    assign ser_last  = ser_valid && w_cnt_zero;
    assign rem_out   = r_rem_out;
    assign rem_valid = r_rem_valid;
    assign divisible = (r_rem_out == 2'd0);

endmodule

// File: tb/tb_modulo3_serializer.sv
// tb/tb_modulo3_serializer.sv - self-checking bench for modulo3_serializer at WIDTH 8 and 4
module tb_modulo3_serializer;

    logic       clk;
    logic       rst_n;

    logic [7:0] d8;
    logic       v8, rdy8, sb8, sv8, sf8, sl8, sr8, rv8, dv8;
    logic [1:0] ro8;

    logic [3:0] d4;
    logic       v4, rdy4, sb4, sv4, sf4, sl4, sr4, rv4, dv4;
    logic [1:0] ro4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    modulo3_serializer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d8), .in_valid(v8), .in_ready(rdy8),
        .ser_bit(sb8), .ser_valid(sv8), .ser_first(sf8), .ser_last(sl8), .ser_ready(sr8),
        .rem_out(ro8), .rem_valid(rv8), .divisible(dv8)
    );

    modulo3_serializer #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d4), .in_valid(v4), .in_ready(rdy4),
        .ser_bit(sb4), .ser_valid(sv4), .ser_first(sf4), .ser_last(sl4), .ser_ready(sr4),
        .rem_out(ro4), .rem_valid(rv4), .divisible(dv4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready8(output int acc);
        int n;
        n = 0;
        while (rdy8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready8_wait", {31'd0, rdy8}, 32'd1);
        acc = cyc;
    endtask

    // Drives one WIDTH=8 frame; expectations come from shifting/modding the word directly.
    task automatic send8(input logic [7:0] w, input int stall_bit, input int stall_len,
                         input bit keep, input logic [7:0] nw, output int acc);
        logic [7:0] word;
        word = w;
        wait_ready8(acc);
        d8 = word;
        v8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("ser_bit",   {31'd0, sb8}, 32'((word >> (7 - k)) & 8'd1));
            chk("ser_valid", {31'd0, sv8}, 32'd1);
            chk("ser_first", {31'd0, sf8}, 32'(k == 0));
            chk("ser_last",  {31'd0, sl8}, 32'(k == 7));
            chk("busy_ready", {31'd0, rdy8}, 32'd0);
            chk("rv_midframe", {31'd0, rv8}, 32'd0);
            d8 = nw;
            v8 = keep;
            if (k == stall_bit) begin
                sr8 = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_bit",   {31'd0, sb8}, 32'((word >> (7 - k)) & 8'd1));
                    chk("stall_valid", {31'd0, sv8}, 32'd1);
                    chk("stall_last",  {31'd0, sl8}, 32'(k == 7));
                end
                sr8 = 1'b1;
            end
        end
        @(negedge clk);
        chk("rem_valid", {31'd0, rv8}, 32'd1);
        chk("rem_out",   {30'd0, ro8}, 32'(word % 8'd3));
        chk("divisible", {31'd0, dv8}, 32'((word % 8'd3) == 0));
        chk("eof_ready", {31'd0, rdy8}, 32'd1);
        chk("eof_valid", {31'd0, sv8}, 32'd0);
        chk("frame_len", 32'(cyc - acc), 32'(9 + ((stall_bit >= 0 && stall_bit < 8) ? stall_len : 0)));
    endtask

    initial begin
        logic [7:0] b2b [6];
        int acc, prev, n;
        logic [7:0] rw;
        int sb, sl;

        b2b = '{8'd6, 8'd7, 8'd45, 8'd96, 8'd100, 8'd255};
        rst_n = 1'b0;
        d8 = 8'd0; v8 = 1'b0; sr8 = 1'b1;
        d4 = 4'd0; v4 = 1'b0; sr4 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_in_ready",  {31'd0, rdy8}, 32'd1);
        chk("rst_ser_valid", {31'd0, sv8},  32'd0);
        chk("rst_ser_first", {31'd0, sf8},  32'd0);
        chk("rst_ser_last",  {31'd0, sl8},  32'd0);
        chk("rst_ser_bit",   {31'd0, sb8},  32'd0);
        chk("rst_rem_out",   {30'd0, ro8},  32'd0);
        chk("rst_rem_valid", {31'd0, rv8},  32'd0);
        chk("rst_divisible", {31'd0, dv8},  32'd1);

        send8(8'h00, -1, 0, 1'b0, 8'h00, acc);
        @(negedge clk);
        chk("rv_one_cycle", {31'd0, rv8}, 32'd0);

        prev = 0;
        for (int i = 0; i < 6; i++) begin
            send8(b2b[i], -1, 0, (i < 5), (i < 5) ? b2b[(i + 1) % 6] : 8'h00, acc);
            if (i > 0) chk("b2b_spacing", 32'(acc - prev), 32'd9);
            prev = acc;
        end

        send8(8'd98, 4, 3, 1'b0, 8'h00, acc);
        @(negedge clk);
        chk("rv_after_stall", {31'd0, rv8}, 32'd0);
        chk("rem_hold",       {30'd0, ro8}, 32'd2);

        send8(8'hA5, -1, 0, 1'b1, 8'h3C, acc);
        prev = acc;
        send8(8'h3C, -1, 0, 1'b0, 8'h00, acc);
        chk("intruder_spacing", 32'(acc - prev), 32'd9);

        send8(8'd7, -1, 0, 1'b0, 8'h00, acc);
        wait_ready8(acc);
        d8 = 8'hFF;
        v8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            v8 = 1'b0;
        end
        chk("pre_rst_rem", {30'd0, ro8}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid",  {31'd0, sv8},  32'd0);
        chk("mid_rst_ready",  {31'd0, rdy8}, 32'd1);
        chk("mid_rst_rem",    {30'd0, ro8},  32'd0);
        chk("mid_rst_div",    {31'd0, dv8},  32'd1);
        chk("mid_rst_rv",     {31'd0, rv8},  32'd0);
        chk("mid_rst_first",  {31'd0, sf8},  32'd0);
        chk("mid_rst_last",   {31'd0, sl8},  32'd0);
        chk("mid_rst_bit",    {31'd0, sb8},  32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_no_rv", {31'd0, rv8}, 32'd0);
        end
        send8(8'd7, -1, 0, 1'b0, 8'h00, acc);

        repeat (25) begin
            rw = 8'($urandom);
            sb = int'($urandom_range(0, 9));
            sl = int'($urandom_range(1, 4));
            send8(rw, sb, sl, 1'b0, 8'($urandom), acc);
        end

        v4 = 1'b1;
        d4 = 4'd0;
        for (int w = 0; w < 16; w++) begin
            n = 0;
            while (rdy4 !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("in_ready4_wait", {31'd0, rdy4}, 32'd1);
            acc = cyc;
            d4 = 4'(w);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("w4_bit",   {31'd0, sb4}, 32'((w >> (3 - k)) & 1));
                chk("w4_first", {31'd0, sf4}, 32'(k == 0));
                chk("w4_last",  {31'd0, sl4}, 32'(k == 3));
                d4 = 4'(w + 1);
                v4 = (w < 15);
            end
            @(negedge clk);
            chk("w4_rv",     {31'd0, rv4}, 32'd1);
            chk("w4_rem",    {30'd0, ro4}, 32'(w % 3));
            chk("w4_div",    {31'd0, dv4}, 32'((w % 3) == 0));
            chk("w4_period", 32'(cyc - acc), 32'd5);
        end
        v4 = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulo3_serializer.md
# modulo3_serializer

Transmit-side companion to the divisible-by-3 checker. Accepts a parallel word over a valid/ready handshake and emits it MSB-first as a serial bit stream with first/last framing and downstream backpressure. The stream is the input format of the serial mod-3 detector. While shifting, the block computes its own running remainder mod 3 and reports it at end of frame, so a bench can cross-check a downstream detector against it.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  WIDTH  parallel word to transmit; sampled only on an accepted handshake.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- ser_bit  output  1  current serial bit, MSB first.
- ser_valid  output  1  ser_bit is valid.
- ser_first  output  1  ser_bit is bit WIDTH-1 of the word.
- ser_last  output  1  ser_bit is bit 0 of the word.
- ser_ready  input  1  downstream accepts ser_bit this cycle.
- rem_out  output  2  remainder mod 3 of the last completed word (0, 1 or 2).
- rem_valid  output  1  one-cycle pulse: rem_out has just been updated.
- divisible  output  1  equals (rem_out == 0).

## Operation
- Two states:
  - IDLE: in_ready=1, ser_valid=0.
  - SHIFT: in_ready=0, ser_valid=1.
- IDLE→SHIFT on in_valid && in_ready. On that transition:
  - load shift register with in_data;
  - clear bit counter to WIDTH-1;
  - clear running remainder r to 0.
- In SHIFT:
  - ser_bit = shift register MSB.
  - ser_first = (counter == WIDTH-1).
  - ser_last = (counter == 0).
- A bit is transferred when ser_valid && ser_ready. On each transfer:
  - r ← (2r + ser_bit) mod 3, using 2-bit arithmetic with no wider intermediate; r stays in {0,1,2}.
  - shift register shifts left by one;
  - counter decrements.
- Transfer with ser_last=1:
  - rem_out ← final r, i.e. (2r + ser_bit) mod 3;
  - rem_valid=1 on the next cycle;
  - state → IDLE.
- ser_ready=0 in SHIFT: ser_bit, ser_first, ser_last, counter and r all hold. ser_valid stays 1; it never drops mid-frame.
- in_valid while in SHIFT: ignored, not accepted. The upstream source must hold the word until in_ready.
- in_data changes after acceptance: no effect on the frame in flight.
- Reset, including mid-frame:
  - state IDLE; frame abandoned;
  - in_ready=1, ser_valid=0, ser_first=0, ser_last=0, ser_bit=0;
  - rem_out=0, rem_valid=0, divisible=1.
  - No partial remainder is reported.

## Timing
- All outputs are registered or decoded from registered state only. ser_ready and in_valid have no combinational path to any output.
- Accept at cycle T: ser_valid=1 with MSB and ser_first=1 at T+1.
- With ser_ready held at 1, bit k (MSB=0) is presented at T+1+k. ser_last is presented at T+WIDTH.
- End of frame: rem_valid=1 and in_ready=1 at T+WIDTH+1. A new word may be accepted in that same cycle.
- Peak throughput: one word per WIDTH+1 cycles.
- Each cycle with ser_ready=0 in SHIFT adds one cycle to the frame.
- rem_out and divisible hold until the next completed frame. rem_valid lasts exactly one cycle.

## Test plan
- Reset, then word 0x00 (WIDTH=8), ser_ready=1:
  - ser_bit = 0,0,0,0,0,0,0,0;
  - ser_first on bit 1 only, ser_last on bit 8 only;
  - rem_out=0, divisible=1, rem_valid pulse at T+9.
- Words 6, 7, 45, 96, 100, 255 back-to-back, in_valid held high:
  - rem_out = 0, 1, 0, 0, 1, 0 respectively;
  - each accepted in the cycle its predecessor's rem_valid pulses;
  - 9-cycle spacing between accepts.
- Word 98 (0b01100010) with ser_ready low for 3 cycles after bit 4:
  - bit 4 (value 0) held stable with ser_valid=1;
  - frame completes at T+12;
  - rem_out=2, divisible=0.
- in_valid asserted with a different word mid-frame:
  - in_ready stays 0; the in-flight frame's bits are unchanged;
  - the second word is accepted only after rem_valid.
- rst_n low for one cycle at bit 5 of word 255 (previous rem_out=1):
  - the next cycle shows ser_valid=0, in_ready=1, rem_out=0, no rem_valid pulse;
  - then word 7 → rem_out=1.
- WIDTH=4, exhaustive words 0..15:
  - rem_out == word mod 3 for every word;
  - 5-cycle frame period with ser_ready=1.
